// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: mem_func codes,
// FSM state encoding and byte-enable / lane constants.
package mem_ctrl_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int LANE_BITS = 8;

    // mem_func codes shared with the MEM stage decoder
    localparam logic [2:0] MF_BS = 3'd0;
    localparam logic [2:0] MF_HS = 3'd1;
    localparam logic [2:0] MF_WD = 3'd2;
    localparam logic [2:0] MF_WL = 3'd3;
    localparam logic [2:0] MF_WR = 3'd4;

    localparam logic [BE_W-1:0] BE_ALL     = 4'b1111;
    localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_LO_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_HI_HALF = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_gen.sv
// Combinational byte-enable, store-lane alignment and misalignment detection
// for one access, derived from mem_func and the low address bits.
module mem_lane_gen
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]        func,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [BE_W-1:0]   byte_en,
    output logic [DATA_W-1:0] lane_data,
    output logic              misaligned
);

    always_comb begin
        byte_en    = BE_ALL;
        lane_data  = wdata;
        misaligned = 1'b0;
        case (func)
            MF_BS: begin
                byte_en   = BE_BYTE0 << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            MF_HS: begin
                byte_en    = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                lane_data  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            // WL/WR are the partial-word halves of an unaligned word access
            MF_WL: begin
                byte_en   = BE_ALL >> addr_lo;
                lane_data = wdata >> (LANE_BITS * addr_lo);
            end
            MF_WR: begin
                byte_en   = BE_ALL << (2'd3 - addr_lo);
                lane_data = wdata << (LANE_BITS * (2'd3 - addr_lo));
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller: issues one bus access per request and
// stalls the pipeline until the response. Optional ISSUE timeout: MEM_TIMEOUT_EN.
//
//   state   | meaning
//   S_IDLE  | waiting for ReqValid; decode, register bus fields, check alignment
//   S_ISSUE | MemReq held with stable bus fields until MemAck (or timeout)
//   S_RESP  | RespValid for one cycle with LoadData/AddrErr/BusErr, then IDLE
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    input  logic              IsStore,
    input  logic [2:0]        MemfuncIn,
    input  logic [ADDR_W-1:0] AddrIn,
    input  logic [DATA_W-1:0] WriteDataIn,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [BE_W-1:0]   MemByteEn,
    output logic [DATA_W-1:0] MemWData,
    output logic              Stall,
    output logic              RespValid,
    output logic [DATA_W-1:0] LoadData,
    output logic              AddrErr,
    output logic              BusErr
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                store_q, store_d;
    logic [DATA_W-1:0]   load_q, load_d;
    logic                addr_err_q, addr_err_d;

    logic [BE_W-1:0]     lane_be;
    logic [DATA_W-1:0]   lane_data;
    logic                lane_misaligned;

    mem_lane_gen u_lane_gen (
        .func       (MemfuncIn),
        .addr_lo    (AddrIn[1:0]),
        .wdata      (WriteDataIn),
        .byte_en    (lane_be),
        .lane_data  (lane_data),
        .misaligned (lane_misaligned)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             timeout_hit;

    // Terminal count is reached in the ISSUE cycle that would make the count equal TIMEOUT_CYCLES
    assign timeout_hit = (state_q == S_ISSUE) && !MemAck &&
                         ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            store_q    <= 1'b0;
            load_q     <= '0;
            addr_err_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            store_q    <= store_d;
            load_q     <= load_d;
            addr_err_q <= addr_err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        store_d    = store_q;
        load_d     = load_q;
        addr_err_d = addr_err_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        bus_err_d  = bus_err_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d     = '0;
                bus_err_d = 1'b0;
`endif
                if (ReqValid) begin
                    addr_err_d = lane_misaligned;
                    if (lane_misaligned) begin
                        state_d = S_RESP;
                    end else begin
                        addr_d  = {AddrIn[ADDR_W-1:2], 2'b00};
                        wdata_d = IsStore ? lane_data : '0;
                        be_d    = IsStore ? lane_be : BE_ALL;
                        store_d = IsStore;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (MemAck) begin
                    load_d  = MemRData;
                    state_d = S_RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // MemReq decodes straight from the async-reset state flop so reset drops it at once
    assign MemReq    = (state_q == S_ISSUE);
    assign MemWe     = MemReq && store_q;
    assign MemAddr   = addr_q;
    assign MemByteEn = be_q;
    assign MemWData  = wdata_q;
    assign RespValid = (state_q == S_RESP);
    assign LoadData  = load_q;
    assign AddrErr   = RespValid && addr_err_q;
    assign Stall     = ReqValid && (state_q != S_RESP);
`ifdef MEM_TIMEOUT_EN
    assign BusErr    = RespValid && bus_err_q;
`else
    assign BusErr    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues expected bus and
// response values; a negedge monitor pops and compares them.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid, IsStore, MemAck;
    logic [2:0]  MemfuncIn;
    logic [31:0] AddrIn, WriteDataIn, MemRData;
    logic        MemReq, MemWe, Stall, RespValid, AddrErr, BusErr;
    logic [31:0] MemAddr, MemWData, LoadData;
    logic [3:0]  MemByteEn;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .IsStore(IsStore),
        .MemfuncIn(MemfuncIn), .AddrIn(AddrIn), .WriteDataIn(WriteDataIn),
        .MemAck(MemAck), .MemRData(MemRData), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemByteEn(MemByteEn), .MemWData(MemWData),
        .Stall(Stall), .RespValid(RespValid), .LoadData(LoadData),
        .AddrErr(AddrErr), .BusErr(BusErr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } bus_t;

    typedef struct {
        int          cyc;
        logic        chk_ld;
        logic [31:0] ld;
        logic        ae;
        logic        berr;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    bus_t  cur;
    resp_t r;
    logic  req_prev = 1'b0;
    logic  resp_prev = 1'b0;

    always @(negedge Clock) begin
        if (Reset) begin
            req_prev  = 1'b0;
            resp_prev = 1'b0;
        end else begin
            if (MemReq) begin
                if (!req_prev) begin
                    if (bus_q.size() == 0) chk("unexpected_memreq", 32'd1, 32'd0);
                    else cur = bus_q.pop_front();
                end
                chk("mem_addr", MemAddr, cur.addr);
                chk("mem_be", {28'd0, MemByteEn}, {28'd0, cur.be});
                chk("mem_we", {31'd0, MemWe}, {31'd0, cur.we});
                if (cur.we) chk("mem_wdata", MemWData, cur.wd);
                chk("stall_issue", {31'd0, Stall}, 32'd1);
            end
            if (RespValid) begin
                if (resp_prev) chk("resp_one_cycle", 32'd1, 32'd0);
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_cycle", cyc, r.cyc);
                    if (r.chk_ld) chk("load_data", LoadData, r.ld);
                    chk("addr_err", {31'd0, AddrErr}, {31'd0, r.ae});
                    chk("bus_err", {31'd0, BusErr}, {31'd0, r.berr});
                    chk("stall_resp", {31'd0, Stall}, 32'd0);
                    chk("memreq_resp", {31'd0, MemReq}, 32'd0);
                end
            end else begin
                chk("err_flags_idle", {30'd0, AddrErr, BusErr}, 32'd0);
            end
            req_prev  = MemReq;
            resp_prev = RespValid;
        end
    end

    // One request; ack_at = ISSUE cycle (1-based) that sees MemAck, 0 = never
    task automatic txn(input logic st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input int ack_at, input logic [31:0] rd,
                       input logic has_req, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input int lat, input logic ae, input logic berr);
        bus_t  b;
        resp_t rr;
        int    n;
        logic  done;
        @(posedge Clock); #1;
        b = '{addr: e_addr, be: e_be, wd: e_wd, we: st};
        rr = '{cyc: cyc + lat, chk_ld: has_req && !st && !berr, ld: rd, ae: ae, berr: berr};
        if (has_req) bus_q.push_back(b);
        resp_q.push_back(rr);
        ReqValid = 1'b1; IsStore = st; MemfuncIn = f; AddrIn = a; WriteDataIn = d;
        MemRData = rd; MemAck = 1'b0;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge Clock); #1;
            if (RespValid) begin
                done = 1'b1;
                MemAck = 1'b0;
                @(negedge Clock); #1;
                ReqValid = 1'b0;
            end else if (MemReq) begin
                n++;
                MemAck = (n == ack_at);
            end
        end
        if (!done) begin
            chk("txn_timeout", 32'd1, 32'd0);
            ReqValid = 1'b0;
            MemAck = 1'b0;
        end
    endtask

    initial begin
        bus_t b;
        Reset = 1'b1; ReqValid = 1'b0; IsStore = 1'b0; MemfuncIn = MF_WD;
        AddrIn = '0; WriteDataIn = '0; MemAck = 1'b0; MemRData = '0;
        #2;
        chk("rst_ctrl", {26'd0, MemReq, MemWe, RespValid, AddrErr, BusErr, Stall}, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_be", {28'd0, MemByteEn}, 32'd0);
        chk("rst_wdata", MemWData, 32'd0);
        chk("rst_load", LoadData, 32'd0);
        @(negedge Clock); Reset = 1'b0;

        //  st  func   addr          data          ack rdata         req e_addr        e_be     e_wd          lat ae be
        txn(0, MF_WD, 32'h0000_0100, 32'h0,        2, 32'hDEADBEEF, 1, 32'h0000_0100, 4'b1111, 32'h0,        3, 0, 0);
        txn(1, MF_BS, 32'h0000_0103, 32'h0000_00AB, 1, 32'h0,       1, 32'h0000_0100, 4'b1000, 32'hABABABAB, 2, 0, 0);
        txn(1, MF_WL, 32'h0000_0201, 32'h11223344, 1, 32'h0,        1, 32'h0000_0200, 4'b0111, 32'h00112233, 2, 0, 0);
        txn(0, MF_HS, 32'h0000_0301, 32'h0,        1, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        1, 1, 0);
        txn(1, MF_HS, 32'h0000_0302, 32'h0000BEEF, 1, 32'h0,        1, 32'h0000_0300, 4'b1100, 32'hBEEFBEEF, 2, 0, 0);
        txn(1, MF_WR, 32'h0000_0402, 32'h11223344, 1, 32'h0,        1, 32'h0000_0400, 4'b1110, 32'h22334400, 2, 0, 0);
        txn(1, MF_WD, 32'h0000_0505, 32'h12345678, 1, 32'h0,        0, 32'h0,         4'b0000, 32'h0,        1, 1, 0);
        txn(1, 3'd7,  32'h0000_0600, 32'hCAFEF00D, 1, 32'h0,        1, 32'h0000_0600, 4'b1111, 32'hCAFEF00D, 2, 0, 0);
        txn(1, MF_WL, 32'h0000_0203, 32'h11223344, 1, 32'h0,        1, 32'h0000_0200, 4'b0001, 32'h00000011, 2, 0, 0);
        txn(1, MF_WR, 32'h0000_0200, 32'h11223344, 1, 32'h0,        1, 32'h0000_0200, 4'b1000, 32'h44000000, 2, 0, 0);
        txn(0, MF_BS, 32'h0000_0101, 32'h0,        1, 32'h12345678, 1, 32'h0000_0100, 4'b1111, 32'h0,        2, 0, 0);
`ifdef MEM_TIMEOUT_EN
        txn(0, MF_WD, 32'h0000_0800, 32'h0,        0, 32'h0,        1, 32'h0000_0800, 4'b1111, 32'h0,        5, 0, 1);
        txn(0, MF_WD, 32'h0000_0804, 32'h0,        4, 32'h5A5A5A5A, 1, 32'h0000_0804, 4'b1111, 32'h0,        5, 0, 0);
`else
        txn(0, MF_WD, 32'h0000_0800, 32'h0,       20, 32'h5A5A5A5A, 1, 32'h0000_0800, 4'b1111, 32'h0,       21, 0, 0);
`endif

        // Reset in the middle of ISSUE
        @(posedge Clock); #1;
        b = '{addr: 32'h0000_0700, be: 4'b1111, wd: 32'h0, we: 1'b0};
        bus_q.push_back(b);
        ReqValid = 1'b1; IsStore = 1'b0; MemfuncIn = MF_WD; AddrIn = 32'h0000_0700; MemAck = 1'b0;
        @(posedge Clock); #1;
        chk("mid_issue_req", {31'd0, MemReq}, 32'd1);
        @(posedge Clock); #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("async_rst_addr", MemAddr, 32'd0);
        @(negedge Clock); #1;
        ReqValid = 1'b0;
        Reset = 1'b0;
        MemAck = 1'b1;
        MemRData = 32'hBAD0BAD0;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock); #1;
            chk("late_ack_ignored", {30'd0, MemReq, RespValid}, 32'd0);
        end
        MemAck = 1'b0;
        txn(0, MF_WD, 32'h0000_0900, 32'h0,        1, 32'h01020304, 1, 32'h0000_0900, 4'b1111, 32'h0,        2, 0, 0);

        repeat (3) @(posedge Clock);
        #1;
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("resp_q_drained", resp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: cycles in ISSUE without MemAck before abort; used only when MEM_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port ReqValid, input, 1 bit: MEM stage requests an access; held stable while Stall=1.
REQ-005 The block SHALL have port IsStore, input, 1 bit: 1 means store, 0 means load.
REQ-006 The block SHALL have port MemfuncIn, input, 3 bits: BS/HS/WD/WL/WR code, encoded per the shared mem_func definitions.
REQ-007 The block SHALL have ports AddrIn and WriteDataIn, input, 32 bits each: byte address and store data (MemWriteData from MEM).
REQ-008 The block SHALL have ports MemAck (input, 1 bit: memory accepted/completed) and MemRData (input, 32 bits: read word, valid with MemAck).
REQ-009 The block SHALL have outputs MemReq (1), MemWe (1), MemAddr (32, word-aligned), MemByteEn (4) and MemWData (32): the external memory bus.
REQ-010 The block SHALL have outputs Stall (1), RespValid (1), LoadData (32), AddrErr (1) and BusErr (1): pipeline status and result.

Function
REQ-011 The FSM SHALL have three states, IDLE, ISSUE and RESP, with IDLE as the reset state.
REQ-012 In IDLE with ReqValid=1 and an aligned address, the block SHALL register address, data, byte enables and IsStore, then enter ISSUE on the next edge.
REQ-013 In ISSUE, MemReq SHALL be 1 and the bus outputs SHALL be stable; on MemAck=1 the block SHALL capture MemRData into LoadData and enter RESP.
REQ-014 In RESP, RespValid SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally.
REQ-015 Stall SHALL be ReqValid AND (state != RESP), combinational, so minimum request-to-release is 3 cycles when MemAck arrives in the first ISSUE cycle.
REQ-016 MemAddr SHALL equal {Addr[31:2],2'b00}.
REQ-017 MemByteEn SHALL be: BS one-hot at lane Addr[1:0]; HS 4'b0011 or 4'b1100 by Addr[1]; WD 4'b1111; WL 4'b1111>>Addr[1:0]; WR (4'b1111<<(3-Addr[1:0]))&4'hF.
REQ-018 MemWData SHALL be: BS byte replicated to all lanes; HS halfword replicated; WD unchanged; WL WriteDataIn>>(8*Addr[1:0]); WR WriteDataIn<<(8*(3-Addr[1:0])).
REQ-019 For loads, MemByteEn SHALL be 4'b1111 and MemWe SHALL be 0; for stores MemWe SHALL be 1.
REQ-020 A misaligned access (HS with Addr[0]=1, or WD with Addr[1:0]!=0) SHALL go directly IDLE to RESP with AddrErr=1 and no MemReq.
REQ-021 AddrErr and BusErr SHALL be valid only while RespValid=1 and SHALL be 0 otherwise.
REQ-022 MemAck in IDLE or RESP SHALL be ignored.
REQ-023 An unlisted MemfuncIn code SHALL be treated as WD.

Reset
REQ-024 Reset SHALL asynchronously force state IDLE, with MemReq, MemWe, RespValid, AddrErr and BusErr at 0, and MemAddr, MemByteEn, MemWData and LoadData at 0.
REQ-025 Reset during ISSUE SHALL drop MemReq immediately, without waiting for a clock edge, and discard the transaction.

Configuration
REQ-026 With MEM_TIMEOUT_EN defined, a counter SHALL clear on ISSUE entry and increment each ISSUE cycle without MemAck.
REQ-027 With MEM_TIMEOUT_EN defined, the block SHALL enter RESP with BusErr=1 and MemReq=0 when the counter reaches TIMEOUT_CYCLES; MemAck in that same cycle SHALL win, giving normal completion.
REQ-028 Without MEM_TIMEOUT_EN, no counter SHALL exist, ISSUE SHALL wait indefinitely, and BusErr SHALL be tied to 0.

Structure
REQ-029 The state enum and the byte-enable/lane-shift constants SHALL live in shared package mem_ctrl_pkg, and the mem_func codes SHALL be reused from the shared definitions.
REQ-030 Byte-enable and lane generation SHALL be in combinational sub-module mem_lane_gen, instantiated once.

Verification
REQ-031 Bench SHALL cover: load WD at 0x100, MemAck on 2nd ISSUE cycle, MemRData=0xDEADBEEF -> RespValid in cycle 4, LoadData=0xDEADBEEF, MemWe=0.
REQ-032 Bench SHALL cover: store BS at 0x103, data 0x000000AB -> MemByteEn=4'b1000, MemWData=0xABABABAB, MemAddr=0x100.
REQ-033 Bench SHALL cover: store WL at 0x201, data 0x11223344 -> MemByteEn=4'b0111, MemWData=0x00112233.
REQ-034 Bench SHALL cover: load HS at 0x301 -> no MemReq, RespValid=1 with AddrErr=1 one cycle after request.
REQ-035 Bench SHALL cover: with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, MemAck held 0 -> BusErr=1 after 4 ISSUE cycles; MemAck in cycle 4 -> no BusErr.
REQ-036 Bench SHALL cover: Reset asserted mid-ISSUE -> MemReq=0 asynchronously, state IDLE, and a later MemAck is ignored.
